// File: rtl/circ_mvm_sequencer.sv
// rtl/circ_mvm_sequencer.sv - circulant matrix-vector multiply pass sequencer
// Optional watchdog: define CIRC_MVM_SEQ_WATCHDOG_EN.
module circ_mvm_sequencer #(
    parameter int WORD_WIDTH     = 31,
    parameter int MTX_SIZE       = 16,
    parameter int NUM_PASSES     = 1,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int PC_W          = $clog2(NUM_PASSES + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  in_vec,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  out_vec,
    output logic                                 out_err,
    output logic                                 dp_start,
    output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  dp_vec,
    input  logic                                 dp_valid,
    input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  dp_result,
    output logic                                 busy,
    output logic [PC_W-1:0]                      pass_cnt
);

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

    localparam logic [PC_W-1:0] LAST_PASS = PC_W'(NUM_PASSES - 1);

    state_t                               state;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  op_reg;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]  out_reg;

    if (NUM_PASSES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("circ_mvm_sequencer: NUM_PASSES and TIMEOUT_CYCLES must be >= 1");
    end

    assign dp_vec  = op_reg;
    assign out_vec = out_reg;

`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign out_err = 1'b0;
`endif

    // Handshake flags are flops updated alongside every state transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            op_reg    <= '0;
            out_reg   <= '0;
            pass_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dp_start  <= 1'b0;
            busy      <= 1'b0;
`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
            wd_cnt    <= '0;
            out_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_reg   <= in_vec;
                        pass_cnt <= '0;
                        in_ready <= 1'b0;
                        dp_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    // dp_valid is not looked at here: it may still be left over from the prior pass.
                    dp_start <= 1'b0;
`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
                    wd_cnt   <= '0;
`endif
                    state    <= WAIT;
                end
                WAIT: begin
                    if (dp_valid) begin
                        if (pass_cnt == LAST_PASS) begin
                            out_reg   <= dp_result;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            op_reg   <= dp_result;
                            pass_cnt <= pass_cnt + PC_W'(1);
                            dp_start <= 1'b1;
                            state    <= START;
                        end
                    end
`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        out_reg   <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        pass_cnt  <= '0;
`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
                        out_err   <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circ_mvm_sequencer.sv
// tb/tb_circ_mvm_sequencer.sv - scoreboard bench for circ_mvm_sequencer (1-pass and 2-pass instances)
module tb_circ_mvm_sequencer;

    localparam int WW = 31;
    localparam int N  = 16;
    localparam int L  = 3;
    localparam int TO = 8;

    typedef logic [N-1:0][WW-1:0] vec_t;
    typedef struct packed {
        vec_t vec;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic in_valid[2], in_ready[2], out_valid[2], out_ready[2], out_err[2];
    logic dp_start[2], dp_valid[2], busy[2];
    vec_t in_vec[2], out_vec[2], dp_vec[2], dp_result[2];
    logic [0:0] pc0;
    logic [1:0] pc1;

    int tests = 0;
    int fails = 0;
    int starts[2];
    exp_t exp_q[2][$];

    circ_mvm_sequencer #(.WORD_WIDTH(WW), .MTX_SIZE(N), .NUM_PASSES(1), .TIMEOUT_CYCLES(TO)) u_dut1 (
        .clk(clk), .reset(resetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(in_vec[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_vec(out_vec[0]), .out_err(out_err[0]),
        .dp_start(dp_start[0]), .dp_vec(dp_vec[0]), .dp_valid(dp_valid[0]), .dp_result(dp_result[0]),
        .busy(busy[0]), .pass_cnt(pc0)
    );

    circ_mvm_sequencer #(.WORD_WIDTH(WW), .MTX_SIZE(N), .NUM_PASSES(2), .TIMEOUT_CYCLES(TO)) u_dut2 (
        .clk(clk), .reset(resetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(in_vec[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_vec(out_vec[1]), .out_err(out_err[1]),
        .dp_start(dp_start[1]), .dp_vec(dp_vec[1]), .dp_valid(dp_valid[1]), .dp_result(dp_result[1]),
        .busy(busy[1]), .pass_cnt(pc1)
    );

    function automatic vec_t ramp(int m);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = WW'(i * m);
        return v;
    endfunction

    function automatic vec_t all_v(int x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = WW'(x);
        return v;
    endfunction

    function automatic int vsum(vec_t v);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(v[i]);
        return s;
    endfunction

    // Datapath model: all-ones circulant row, result valid L cycles after dp_start, held as a level.
    logic mdl_valid[2];
    vec_t mdl_res[2];
    int   mdl_cnt[2];
    logic force_v[2], hang[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            mdl_valid[k] = 1'b0;
            mdl_res[k]   = '0;
            mdl_cnt[k]   = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dp_start[k]) begin
                mdl_res[k]   <= all_v(vsum(dp_vec[k]));
                mdl_cnt[k]   <= 1;
                mdl_valid[k] <= 1'b0;
            end else if (!mdl_valid[k] && mdl_cnt[k] > 0) begin
                if (mdl_cnt[k] == L - 1) mdl_valid[k] <= 1'b1;
                else mdl_cnt[k] <= mdl_cnt[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            dp_valid[k]  = (mdl_valid[k] | force_v[k]) & ~hang[k];
            dp_result[k] = mdl_res[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (dp_start[k]) starts[k]++;
    end

    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (resetn && out_valid[k] && out_ready[k]) begin
                tests++;
                if (exp_q[k].size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected[%0d]: got output %0h err=%0b, required no output", k, out_vec[k], out_err[k]);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    if (out_vec[k] !== e.vec || out_err[k] !== e.err) begin
                        fails++;
                        $display("FAIL sb_result[%0d]: got %0h err=%0b, required %0h err=%0b",
                                 k, out_vec[k], out_err[k], e.vec, e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int k, input vec_t v, input logic err);
        exp_t e;
        e.vec = v;
        e.err = err;
        exp_q[k].push_back(e);
    endtask

    // Returns at the negedge of the cycle after the input handshake (cycle 1).
    task automatic send(input int k, input vec_t v);
        int n = 0;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_vec[k]   = v;
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready[k], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int n0, output int n);
        n = n0;
        while (!out_valid[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", out_valid[k], 1'b1);
    endtask

    initial begin
        int   n;
        int   ns;
        vec_t snap;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_vec[k]    = '0;
            out_ready[k] = 1'b1;
            force_v[k]   = 1'b0;
            hang[k]      = 1'b0;
            starts[k]    = 0;
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready[0], 1'b1);
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_dp_start", dp_start[0], 1'b0);
        chk("rst_out_err", out_err[0], 1'b0);
        chk("rst_pass_cnt", pc0, 1'b0);
        chk_vec("rst_out_vec", out_vec[0], '0);
        chk_vec("rst_dp_vec", dp_vec[0], '0);
        chk("rst_in_ready2", in_ready[1], 1'b1);
        chk("rst_pass_cnt2", pc1, 2'd0);
        resetn = 1'b1;

        // single pass, latency and start count
        starts[0] = 0;
        push_exp(0, all_v(120), 1'b0);
        send(0, ramp(1));
        wait_out(0, 1, n);
        chk("lat_1pass", n, 5);
        @(negedge clk);
        chk("starts_1pass", starts[0], 1);
        chk("idle_after_hs", in_ready[0], 1'b1);

        // two passes: operand feedback and pass counter
        starts[1] = 0;
        ns = 0;
        push_exp(1, all_v(1920), 1'b0);
        send(1, ramp(1));
        n = 1;
        while (!out_valid[1] && n < 60) begin
            if (dp_start[1]) begin
                ns++;
                if (ns == 1) chk("pass_cnt_p0", pc1, 2'd0);
                else begin
                    chk("pass_cnt_p1", pc1, 2'd1);
                    chk_vec("dp_vec_p1", dp_vec[1], all_v(120));
                end
            end
            @(negedge clk);
            n++;
        end
        chk("lat_2pass", n, 9);
        chk("starts_2pass", ns, 2);
        @(negedge clk);
        chk("starts_2pass_mon", starts[1], 2);

        // output backpressure with in_valid pulses that must be ignored
        starts[0]    = 0;
        out_ready[0] = 1'b0;
        push_exp(0, all_v(32), 1'b0);
        send(0, all_v(2));
        wait_out(0, 1, n);
        snap = out_vec[0];
        in_vec[0] = ramp(5);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = ~in_valid[0];
            @(negedge clk);
            chk_vec("bp_stable", out_vec[0], snap);
            chk("bp_in_ready", in_ready[0], 1'b0);
            chk("bp_out_valid", out_valid[0], 1'b1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid[0], 1'b0);
        chk("bp_release_ready", in_ready[0], 1'b1);
        chk("bp_starts", starts[0], 1);

        // stale dp_valid during START must not be captured
        push_exp(0, all_v(360), 1'b0);
        send(0, ramp(3));
        chk("stale_in_start", dp_start[0], 1'b1);
        force_v[0] = 1'b1;
        @(negedge clk);
        force_v[0] = 1'b0;
        wait_out(0, 2, n);
        chk("lat_stale", n, 5);
        @(negedge clk);

        // reset in WAIT abandons the vector
        send(0, ramp(2));
        @(negedge clk);
        chk("wait_busy", busy[0], 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mid_rst_in_ready", in_ready[0], 1'b1);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_out_valid", out_valid[0], 1'b0);
        repeat (6) @(negedge clk);
        chk("mid_rst_no_out", out_valid[0], 1'b0);
        push_exp(0, all_v(120), 1'b0);
        send(0, ramp(1));
        wait_out(0, 1, n);
        chk("lat_after_rst", n, 5);
        @(negedge clk);

`ifdef CIRC_MVM_SEQ_WATCHDOG_EN
        hang[0] = 1'b1;
        push_exp(0, '0, 1'b1);
        send(0, ramp(1));
        wait_out(0, 1, n);
        chk("lat_watchdog", n, 10);
        chk("wd_err", out_err[0], 1'b1);
        @(negedge clk);
        chk("wd_err_clear", out_err[0], 1'b0);
        chk("wd_valid_clear", out_valid[0], 1'b0);
        hang[0] = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain0", exp_q[0].size(), 0);
        chk("sb_drain1", exp_q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/circ_mvm_sequencer.md
Name: circ_mvm_sequencer

Overview:
- Controller for one circulant matrix-vector multiply datapath, which is instantiated outside this block.
- Accepts an input vector over a valid/ready handshake and holds it stable on the datapath operand bus.
- Restarts the multicycle dot-product units with a start pulse and waits for the datapath valid.
- Either feeds the result back for another pass (repeated linear layer) or presents it downstream over valid/ready.

Parameters:
WORD_WIDTH, 31, bits per field element (M31)
MTX_SIZE, 16, vector length / matrix dimension
NUM_PASSES, 1, passes of the matrix applied per accepted vector (>=1)
TIMEOUT_CYCLES, 256, watchdog limit in cycles per pass (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  sequencer can accept a vector
in_vec  in  WORD_WIDTH x MTX_SIZE  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vec  out  WORD_WIDTH x MTX_SIZE  result vector
out_err  out  1  result aborted by watchdog (0 without the optional feature)
dp_start  out  1  one-cycle pulse that clears and restarts the datapath
dp_vec  out  WORD_WIDTH x MTX_SIZE  operand vector driven to the datapath
dp_valid  in  1  datapath result valid (level)
dp_result  in  WORD_WIDTH x MTX_SIZE  datapath result
busy  out  1  state != IDLE
pass_cnt  out  clog2(NUM_PASSES+1)  current pass index

Behaviour:
- Reset: sampled on the clk rising edge while reset==0.
  - state=IDLE.
  - op_reg, out_reg, pass_cnt and the watchdog counter cleared to 0.
  - in_ready=1, out_valid=0, out_err=0, dp_start=0, busy=0.
- Reset asserted mid-operation abandons the current vector. No output is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid: op_reg<=in_vec, pass_cnt<=0, go to START.
- START, exactly one cycle:
  - dp_start=1, in_ready=0. Watchdog cleared.
  - Go to WAIT.
- WAIT:
  - dp_start=0.
  - dp_valid is ignored in START and is sampled only from the first WAIT cycle. This rejects a stale valid left over from the previous pass.
  - On dp_valid with pass_cnt==NUM_PASSES-1: out_reg<=dp_result, go to OUT.
  - On dp_valid with pass_cnt<NUM_PASSES-1: op_reg<=dp_result, pass_cnt++, go to START.
- OUT:
  - out_valid=1. out_vec=out_reg, held stable while out_ready==0.
  - in_ready=0.
  - On out_ready: go to IDLE, out_valid<=0, pass_cnt<=0.
- dp_vec=op_reg at all times. It is stable from the START cycle until the WAIT exit.
- No arithmetic is performed here. Result words pass through unmodified, WORD_WIDTH bits wide.
- Latency from input handshake to out_valid = NUM_PASSES*(1 + L) + 1 cycles, where L = datapath cycles from dp_start to dp_valid (L>=1).
- Throughput: one vector per the latency above plus one IDLE cycle.
  - Not pipelined.
  - in_ready stays 0 from the input handshake until the cycle after the output handshake.
- Input and output handshakes never occur in the same cycle.
- dp_valid arriving in the same cycle as the watchdog expiring: dp_valid wins.

Optional Feature:
- Macro: CIRC_MVM_SEQ_WATCHDOG_EN.
- When defined:
  - A counter increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without dp_valid, go to OUT with out_reg=0 and out_err=1.
  - out_err holds with out_valid and clears on the output handshake.
  - Remaining passes are skipped.
- When undefined:
  - No counter logic.
  - WAIT lasts until dp_valid arrives.
  - out_err is tied to 0.

Test Plan:
- Datapath model with mtx_row all 1, L=3, NUM_PASSES=1, in_vec=0..15: out_vec all 120; out_valid high 5 cycles after the input handshake; dp_start pulses exactly once.
- NUM_PASSES=2, same model and vector: dp_start pulses twice; dp_vec=120 on every word during pass 1; out_vec all 1920; pass_cnt reads 0 then 1.
- out_ready held 0 for 10 cycles after out_valid: out_vec stable, in_ready=0, in_valid pulses ignored; then out_ready=1 gives the handshake and in_ready=1 on the next cycle.
- dp_valid forced high during the START cycle then low, real valid 3 cycles later: the stale valid is not captured and out_vec equals the real result.
- reset driven to 0 for one cycle during WAIT: next cycle state=IDLE, in_ready=1, busy=0, out_valid=0; a later vector 0..15 yields all 120.
- With CIRC_MVM_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=8, dp_valid never asserted: out_valid with out_err=1 and out_vec all 0 after 1+1+8 cycles; out_err clears after the handshake.
